imem_line_server: RTL
=====================

IMEM_LINE_SERVER -- requirements
Module: imem_line_server

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning wait cycles between request accept and first word read (legal 0..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two, multiple of 4).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 icache_addr_i  input  32  line-fill byte address from the cache; bits [3:0] ignored.
REQ-006 icache_valid_req_i  input  1  fill request; a single-cycle pulse.
REQ-007 mem_ready_o  output  1  one-cycle pulse marking a completed line.
REQ-008 mem_data_o  output  128  line data; word k is at bits [32k+31:32k].
REQ-009 busy_o  output  1  high while a fill is in flight (any state except IDLE).
REQ-010 err_o  output  1  out-of-range flag, qualified by mem_ready_o.
REQ-011 ld_we_i / ld_addr_i[31:0] / ld_data_i[31:0]  input  program-load word write port; ld_addr_i bits [1:0] ignored.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, BEAT and RESP.
REQ-013 IDLE: if icache_valid_req_i=1, latch icache_addr_i[31:4] as the line address, load the latency counter with LATENCY, and go to WAIT. If LATENCY=0, go directly to BEAT.
REQ-014 WAIT: decrement the counter each cycle; go to BEAT in the cycle the counter reaches 1.
REQ-015 BEAT: read one word per cycle, word index = {line address, beat[1:0]}, beats 0..3 in order, each into buffer slot beat; after beat 3, go to RESP.
REQ-016 RESP: mem_ready_o=1 and mem_data_o=buffer for exactly one cycle, then go to IDLE.
REQ-017 Latency: a request accepted at cycle T SHALL see mem_ready_o high at cycle T+LATENCY+5; the next request is acceptable at T+LATENCY+6.
REQ-018 mem_data_o SHALL be all zeros whenever mem_ready_o=0.
REQ-019 icache_valid_req_i in any state other than IDLE (including the RESP cycle) SHALL be ignored, with no queuing and no state change.
REQ-020 ld_we_i=1 SHALL write ld_data_i to word ld_addr_i[..:2] in any state.
REQ-021 If a load write and a BEAT read hit the same word in the same cycle, the read SHALL return the old data.
REQ-022 Storage SHALL be 32-bit words addressed modulo DEPTH_WORDS when the bound check is compiled out.
REQ-023 The latched line address SHALL NOT change while busy; icache_addr_i changes after accept SHALL have no effect.

Reset
REQ-024 On rst_n=0 at a rising edge: state=IDLE, counter=0, beat=0, buffer=0, mem_ready_o=0, mem_data_o=0, busy_o=0, err_o=0.
REQ-025 Reset asserted mid-fill SHALL abort the fill, with no mem_ready_o pulse afterward.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro IMEM_BOUND_CHK_EN, when defined: if the line word index is >= DEPTH_WORDS, the FSM timing SHALL be unchanged, the buffer SHALL load zeros, and err_o=1 SHALL accompany mem_ready_o; out-of-range load writes SHALL be dropped.
REQ-028 When IMEM_BOUND_CHK_EN is undefined: err_o SHALL be tied 0 and all addresses SHALL wrap modulo DEPTH_WORDS.

Verification
REQ-029 Preload words 0x10..0x13 at byte 0x40; request addr 0x0000_004C at T, LATENCY=4 -> mem_ready_o at T+9 only, data=0x00000013_00000012_00000011_00000010, busy_o high T+1..T+9.
REQ-030 LATENCY=0, request at T -> mem_ready_o at T+5; back-to-back request at T+6 accepted, second pulse at T+11.
REQ-031 Extra request pulses at T+2 and T+9 with a different address -> ignored; a single pulse at T+9 carrying the first line.
REQ-032 Load write of 0xDEADBEEF to the beat-2 word during WAIT -> response word 2=0xDEADBEEF; same write in the beat-2 read cycle -> old word returned.
REQ-033 rst_n low at T+6 of an in-flight fill -> no mem_ready_o, busy_o=0 next cycle, next request served normally with preloaded data intact.
REQ-034 IMEM_BOUND_CHK_EN defined, DEPTH_WORDS=1024, request 0x0000_1000 -> data all zeros, err_o=1 with mem_ready_o; undefined -> data of line 0, err_o=0.

Source files
------------

// File: rtl/imem_line_server.sv
// imem_line_server: instruction memory that serves 128-bit cache line fills.
//
// A single-cycle fill request latches the line address, waits LATENCY cycles,
// reads the four words of the line one per cycle into a line buffer, and then
// presents the line for exactly one cycle with mem_ready_o. A separate
// program-load port writes words into storage at any time.
//
// Optional feature macro: IMEM_BOUND_CHK_EN
//   defined   : lines at or beyond DEPTH_WORDS return zeros with err_o=1, and
//               out-of-range load writes are dropped.
//   undefined : err_o is tied low and all addresses wrap modulo DEPTH_WORDS.
//
// Parameters:
//   LATENCY      wait cycles between request accept and first word read (0..15)
//   DEPTH_WORDS  number of 32-bit storage words (power of two, multiple of 4)
//
// Ports:
//   clk                 sole clock, rising edge
//   rst_n               synchronous active-low reset (storage is not cleared)
//   icache_addr_i       line-fill byte address, bits [3:0] ignored
//   icache_valid_req_i  fill request pulse, honoured only when idle
//   mem_ready_o         one-cycle pulse marking a completed line
//   mem_data_o          line data, word k at [32k+31:32k]; zero when not ready
//   busy_o              high while a fill is in flight
//   err_o               out-of-range flag, qualified by mem_ready_o
//   ld_we_i             program-load write enable
//   ld_addr_i           program-load byte address, bits [1:0] ignored
//   ld_data_i           program-load write data

module imem_line_server #(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  icache_addr_i,
    input  logic         icache_valid_req_i,
    output logic         mem_ready_o,
    output logic [127:0] mem_data_o,
    output logic         busy_o,
    output logic         err_o,
    input  logic         ld_we_i,
    input  logic [31:0]  ld_addr_i,
    input  logic [31:0]  ld_data_i
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StBeat, StResp} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         beat_q, beat_d;
    logic [27:0]        line_q, line_d;
    logic [3:0][31:0]   buf_q;
    logic               beat_en;

    logic [31:0]        mem [DEPTH_WORDS];

    logic [29:0]        word_idx;
    logic [AW-1:0]      rd_idx;
    logic [AW-1:0]      wr_idx;
    logic               rd_ok;
    logic               wr_ok;

    assign word_idx = {line_q, beat_q};
    assign rd_idx   = word_idx[AW-1:0];
    assign wr_idx   = ld_addr_i[AW+1:2];

`ifdef IMEM_BOUND_CHK_EN
    // The whole line is in or out of range together since DEPTH_WORDS is a
    // multiple of 4, so the check uses the line base.
    assign rd_ok = ({2'b00, line_q, 2'b00} < 32'(DEPTH_WORDS));
    assign wr_ok = ({2'b00, ld_addr_i[31:2]} < 32'(DEPTH_WORDS));
    assign err_o = (state_q == StResp) && !rd_ok;
`else
    assign rd_ok = 1'b1;
    assign wr_ok = 1'b1;
    assign err_o = 1'b0;
`endif

    // Address bits that are ignored, or dropped by the modulo wrap.
    logic unused_bits;
    assign unused_bits = ^{icache_addr_i[3:0], ld_addr_i, word_idx};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        line_d  = line_q;
        beat_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (icache_valid_req_i) begin
                    line_d  = icache_addr_i[31:4];
                    cnt_d   = 4'(LATENCY);
                    beat_d  = 2'd0;
                    state_d = (LATENCY == 0) ? StBeat : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StBeat;
                end
            end
            StBeat: begin
                beat_en = 1'b1;
                beat_d  = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            beat_q  <= 2'd0;
            line_q  <= 28'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
        end
    end

    // Line buffer; the nonblocking read returns pre-write data on a
    // same-cycle load write to the same word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (beat_en) begin
            buf_q[beat_q] <= rd_ok ? mem[rd_idx] : 32'd0;
        end
    end

    // Storage has no reset so program contents survive a fill abort.
    always_ff @(posedge clk) begin
        if (ld_we_i && wr_ok) begin
            mem[wr_idx] <= ld_data_i;
        end
    end

    assign mem_ready_o = (state_q == StResp);
    assign mem_data_o  = mem_ready_o ? buf_q : 128'd0;
    assign busy_o      = (state_q != StIdle);

endmodule
